mux_share_arbiter: RTL

- Shares one WIDTH-bit 2:1 select datapath between two requesters, A and B.
- Round-robin arbitration with a bounded burst length per grant.
- The selected word is captured into a registered valid/ready output stage that feeds the downstream consumer.
- Sits between two producer blocks and a single consumer; it sequences the select line of the shared mux.

---
 rtl/mux_share_arbiter_pkg.sv | 19 +
 rtl/sel_mux2.sv | 17 +
 rtl/mux_share_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_share_arbiter_pkg.sv
// Shared encodings for the two-requester mux-sharing arbiter:
// FSM state codes, source identifiers and a small state helper.
package mux_share_arbiter_pkg;

  // FSM state codes
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;

  // Source tags carried on out_src and kept in the last-served register
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Map a source tag to the state that serves it
  function automatic logic [1:0] serve_state(input logic src);
    return src ? SERVE_B : SERVE_A;
  endfunction

endpackage

// File: rtl/sel_mux2.sv
// WIDTH-bit 2:1 select: y = s ? b : a, built bit by bit.
module sel_mux2 #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = s ? b[gi] : a[gi];
    end
  endgenerate

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one 2:1 select datapath between requesters
// A and B. A grant lasts at most HOLD_MAX beats while the other side waits;
// the selected word is captured into a valid/ready output register.
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             busy
);

  // Counter just wide enough for 0..HOLD_MAX-1 (at least one bit)
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  logic [1:0]       state_reg, state_next;
  logic             last_reg, last_next;
  logic [CW-1:0]    beat_reg, beat_next;
  logic             sel;
  logic             serving;
  logic             req_cur;
  logic             req_oth;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  assign sel      = (state_reg == SERVE_B);
  assign serving  = (state_reg == SERVE_A) || (state_reg == SERVE_B);
  assign req_cur  = sel ? req_b : req_a;
  assign req_oth  = sel ? req_a : req_b;
  assign can_load = !out_valid || out_ready;
  assign load     = serving && req_cur && can_load;
  assign ack_a    = load && !sel;
  assign ack_b    = load && sel;
  assign busy     = (state_reg != IDLE);

  sel_mux2 #(.WIDTH(WIDTH)) u_sel_mux2 (
    .a (data_a),
    .b (data_b),
    .s (sel),
    .y (mux_y)
  );

  // Next-state logic: grant from IDLE, hand over on drop or exhausted burst.
  // The final word is recognised by req falling the cycle after its ack.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (req_a && req_b) begin
          state_next = serve_state(!last_reg);
        end else if (req_a) begin
          state_next = SERVE_A;
        end else if (req_b) begin
          state_next = SERVE_B;
        end
      end
      SERVE_A, SERVE_B: begin
        if (!req_cur) begin
          state_next = req_oth ? serve_state(!sel) : IDLE;
          last_next  = sel;
          beat_next  = '0;
        end else if (load && (beat_reg == CNT_MAX) && req_oth) begin
          state_next = serve_state(!sel);
          last_next  = sel;
          beat_next  = '0;
        end else if (load && (beat_reg != CNT_MAX)) begin
          beat_next = beat_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Arbitration state: FSM, last-served side and burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= SRC_B;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      beat_reg  <= beat_next;
    end
  end

  // Output register: load the selected word, or empty it once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_A;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
